// File: rtl/noc_port_arbiter.sv
// -----------------------------------------------------------------------------
// noc_port_arbiter
//
// Registered N-input packet arbiter for one NoC router output channel.
// While idle, the block picks one requesting input port. The search is
// round-robin from a rotating pointer, or fixed priority (lowest index first)
// when FIXED_PRIO is set. It then locks onto that port and forwards its flits
// into a one-deep output register. The lock is released when the tail flit
// has been accepted.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_req     per-port "flit available" (head or body)
//   in_tail    per-port "presented flit is the packet tail"
//   in_flit    per-port flit, port i at [i*FLIT_W +: FLIT_W]
//   in_ack     one-hot pop strobe to the owning port (combinational)
//   out_valid  output register holds a flit
//   out_ready  downstream accepts the flit this cycle
//   out_flit   registered flit
//   out_port   source port index of out_flit
//   grant      registered one-hot owner, all-zero while idle
//   busy       high while a port owns the channel
// -----------------------------------------------------------------------------
module noc_port_arbiter #(
  parameter int NUM_PORTS  = 5,
  parameter int FLIT_W     = 32,
  parameter int FIXED_PRIO = 0,
  localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        in_req,
  input  logic [NUM_PORTS-1:0]        in_tail,
  input  logic [NUM_PORTS*FLIT_W-1:0] in_flit,
  output logic [NUM_PORTS-1:0]        in_ack,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FLIT_W-1:0]           out_flit,
  output logic [PORT_W-1:0]           out_port,
  output logic [NUM_PORTS-1:0]        grant,
  output logic                        busy
);

  // Port count at the width of the candidate sum, used for modulo wrap.
  localparam logic [PORT_W:0] NUM_PORTS_W = (PORT_W+1)'(NUM_PORTS);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;

  logic [PORT_W-1:0]      ptr_reg;
  logic [PORT_W-1:0]      ptr_next;
  logic [PORT_W-1:0]      sel_reg;
  logic [NUM_PORTS-1:0]   grant_reg;
  logic                   out_valid_reg;
  logic [FLIT_W-1:0]      out_flit_reg;
  logic [PORT_W-1:0]      out_port_reg;

  // ---------------------------------------------------------------------------
  // Winner search
  // Candidate k is port (start + k) mod NUM_PORTS. Both start and k are below
  // NUM_PORTS, so one conditional subtraction performs the wrap.
  // ---------------------------------------------------------------------------
  logic [PORT_W-1:0]      search_start;
  logic [PORT_W:0]        cand_sum [NUM_PORTS];
  logic [PORT_W-1:0]      cand_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0]   cand_req;
  logic [PORT_W-1:0]      win_idx;
  logic                   win_found;
  logic [NUM_PORTS-1:0]   win_onehot;

  assign search_start = (FIXED_PRIO != 0) ? '0 : ptr_reg;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, search_start} + (PORT_W+1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= NUM_PORTS_W)
                            ? PORT_W'(cand_sum[gi] - NUM_PORTS_W)
                            : PORT_W'(cand_sum[gi]);
      assign cand_req[gi] = in_req[cand_idx[gi]];
    end
  endgenerate

  // The lowest-numbered requesting candidate wins. Scanning downward lets the
  // last hit stand, so no early exit is needed.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_win_onehot
      assign win_onehot[gi] = (win_idx == PORT_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake with the owning port
  // ---------------------------------------------------------------------------
  logic                   ack_any;
  logic                   tail_ack;
  logic [FLIT_W-1:0]      sel_flit;

  // The output register can take a new flit when it is empty or being drained.
  logic                   out_slot_free;

  assign out_slot_free = !out_valid_reg || out_ready;
  assign ack_any       = |in_ack;
  assign tail_ack      = ack_any && in_tail[sel_reg];
  assign sel_flit      = in_flit[sel_reg*FLIT_W +: FLIT_W];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (tail_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // in_ack depends only on registered state, in_req and out_ready. A request
  // drop mid-packet simply produces no ack (a bubble), and the lock is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ack = '0;
    busy   = 1'b0;
    if (state_reg == LOCKED) begin
      busy = 1'b1;
      if (in_req[sel_reg] && out_slot_free) begin
        in_ack[sel_reg] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pointer: after a tail, the port following the owner goes
  // first. With fixed priority the pointer never leaves 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    ptr_next = ptr_reg;
    if (tail_ack) begin
      if ((FIXED_PRIO != 0) || (sel_reg == PORT_W'(NUM_PORTS - 1))) begin
        ptr_next = '0;
      end else begin
        ptr_next = sel_reg + PORT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Owner, grant, pointer and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg       <= '0;
      sel_reg       <= '0;
      grant_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_flit_reg  <= '0;
      out_port_reg  <= '0;
    end else begin
      ptr_reg <= ptr_next;

      // Arbitration cycle: load the owner. No flit moves in this cycle.
      if ((state_reg == IDLE) && win_found) begin
        sel_reg   <= win_idx;
        grant_reg <= win_onehot;
      end

      if (tail_ack) begin
        grant_reg <= '0;
      end

      // A new flit takes priority over draining; otherwise the register
      // empties on acceptance and holds under backpressure.
      if (ack_any) begin
        out_flit_reg  <= sel_flit;
        out_port_reg  <= sel_reg;
        out_valid_reg <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign grant     = grant_reg;
  assign out_valid = out_valid_reg;
  assign out_flit  = out_flit_reg;
  assign out_port  = out_port_reg;

endmodule

// File: tb/tb_noc_port_arbiter.sv
`timescale 1ns/1ps
module tb_noc_port_arbiter;

  localparam int NP    = 5;
  localparam int FW    = 32;
  localparam int PW    = 3;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NP-1:0]   in_req;
  logic [NP-1:0]   in_tail;
  logic [NP*FW-1:0] in_flit;
  logic            out_ready;

  logic [NP-1:0]   in_ack;
  logic            out_valid;
  logic [FW-1:0]   out_flit;
  logic [PW-1:0]   out_port;
  logic [NP-1:0]   grant;
  logic            busy;

  logic [NP-1:0]   fp_in_ack;
  logic            fp_out_valid;
  logic [FW-1:0]   fp_out_flit;
  logic [PW-1:0]   fp_out_port;
  logic [NP-1:0]   fp_grant;
  logic            fp_busy;

  noc_port_arbiter #(.NUM_PORTS(NP), .FLIT_W(FW), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_tail(in_tail), .in_flit(in_flit),
    .in_ack(in_ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_flit(out_flit), .out_port(out_port), .grant(grant), .busy(busy)
  );

  noc_port_arbiter #(.NUM_PORTS(NP), .FLIT_W(FW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .in_req(in_req), .in_tail(in_tail), .in_flit(in_flit),
    .in_ack(fp_in_ack), .out_valid(fp_out_valid), .out_ready(out_ready),
    .out_flit(fp_out_flit), .out_port(fp_out_port), .grant(fp_grant), .busy(fp_busy)
  );

  int checks   = 0;
  int failures = 0;

  // Per-port packet sources: flits popped on in_ack.
  logic [FW-1:0] src_flit [NP][DEPTH];
  bit            src_head [NP][DEPTH];
  bit            src_tail [NP][DEPTH];
  int            src_len  [NP];
  int            src_rd   [NP];

  // Traffic shape for the next build.
  int            npk      [NP];
  int            len_cfg  [NP];
  int            max_len;

  // Expected output stream and observed transfer cycles.
  logic [FW-1:0] exp_flit_q [$];
  int            exp_port_q [$];
  int            xfer_q     [$];

  // Transaction-level model: packets are served whole, and the next packet
  // comes from the first port after the previous winner that still has one
  // queued. Heads are always presented, so every such port competes.
  task automatic build_traffic();
    int  left [NP];
    int  start;
    int  found;
    int  len;
    int  idx;
    bit  done;
    exp_flit_q.delete();
    exp_port_q.delete();
    for (int i = 0; i < NP; i++) begin
      left[i]    = npk[i];
      src_len[i] = 0;
      src_rd[i]  = 0;
    end
    start = 0;
    done  = 1'b0;
    while (!done) begin
      found = -1;
      for (int k = 0; k < NP; k++) begin
        if (found < 0 && left[(start + k) % NP] > 0) found = (start + k) % NP;
      end
      if (found < 0) begin
        done = 1'b1;
      end else begin
        len = (len_cfg[found] > 0) ? len_cfg[found] : int'($urandom_range(1, max_len));
        for (int f = 0; f < len; f++) begin
          idx = src_len[found];
          src_flit[found][idx] = $urandom;
          src_head[found][idx] = (f == 0);
          src_tail[found][idx] = (f == len - 1);
          exp_flit_q.push_back(src_flit[found][idx]);
          exp_port_q.push_back(found);
          src_len[found]++;
        end
        left[found]--;
        start = (found + 1) % NP;
      end
    end
  endtask

  task automatic do_reset();
    in_req    = '0;
    in_tail   = '0;
    in_flit   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Scoreboard scenario: drives the sources, checks the handshake rules each
  // cycle and the output stream against the model.
  task automatic run_traffic(input string name, input int ready_pct,
                             input int bubble_pct, input int limit);
    int            cyc;
    logic          p_valid, p_ready, p_busy, p_tail;
    logic [NP-1:0] p_req, p_ack, p_grant, exp_ack;
    logic [FW-1:0] p_out_flit, p_ack_flit, ef;
    logic [PW-1:0] p_ack_port;
    int            ep;
    cyc = 0;
    p_valid = 1'b0; p_ready = 1'b0; p_busy = 1'b0; p_tail = 1'b0;
    p_req = '0; p_ack = '0; p_grant = '0;
    p_out_flit = '0; p_ack_flit = '0; p_ack_port = '0;
    xfer_q.delete();
    while (exp_flit_q.size() > 0 && cyc < limit) begin
      for (int p = 0; p < NP; p++) begin
        if (src_rd[p] < src_len[p]) begin
          in_req[p]  = src_head[p][src_rd[p]] || ($urandom_range(0, 99) >= bubble_pct);
          in_tail[p] = src_tail[p][src_rd[p]];
          in_flit[p*FW +: FW] = src_flit[p][src_rd[p]];
        end else begin
          in_req[p]  = 1'b0;
          in_tail[p] = 1'($urandom_range(0, 1));
          in_flit[p*FW +: FW] = $urandom;
        end
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);

      checks++;
      if (busy !== (grant != '0) || !$onehot0(grant)) begin
        failures++;
        $display("FAIL %s busy_grant cyc=%0d: busy=%b grant=%b required busy=|grant and one-hot grant",
                 name, cyc, busy, grant);
      end
      exp_ack = busy ? (grant & in_req & {NP{(!out_valid) || out_ready}}) : '0;
      checks++;
      if (in_ack !== exp_ack) begin
        failures++;
        $display("FAIL %s ack cyc=%0d: in_ack=%b required=%b", name, cyc, in_ack, exp_ack);
      end
      if (!p_busy) begin
        checks++;
        if (busy !== (p_req != '0)) begin
          failures++;
          $display("FAIL %s arb_latency cyc=%0d: busy=%b required=%b", name, cyc, busy, (p_req != '0));
        end
      end else if (!(p_ack != '0 && p_tail)) begin
        checks++;
        if (busy !== 1'b1 || grant !== p_grant) begin
          failures++;
          $display("FAIL %s lock_hold cyc=%0d: busy=%b grant=%b required busy=1 grant=%b",
                   name, cyc, busy, grant, p_grant);
        end
      end else begin
        checks++;
        if (busy !== 1'b0 || grant !== '0) begin
          failures++;
          $display("FAIL %s tail_release cyc=%0d: busy=%b grant=%b required 0", name, cyc, busy, grant);
        end
      end
      if (p_ack != '0) begin
        checks++;
        if (out_valid !== 1'b1 || out_flit !== p_ack_flit || out_port !== p_ack_port) begin
          failures++;
          $display("FAIL %s capture cyc=%0d: valid=%b flit=%h port=%0d required 1 %h %0d",
                   name, cyc, out_valid, out_flit, out_port, p_ack_flit, p_ack_port);
        end
      end else if (p_valid && !p_ready) begin
        checks++;
        if (out_valid !== 1'b1 || out_flit !== p_out_flit) begin
          failures++;
          $display("FAIL %s hold cyc=%0d: valid=%b flit=%h required 1 %h",
                   name, cyc, out_valid, out_flit, p_out_flit);
        end
      end else if (p_valid && p_ready) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s drain cyc=%0d: out_valid=%b required 0", name, cyc, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_flit_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_flit cyc=%0d: flit=%h port=%0d required none", name, cyc, out_flit, out_port);
        end else begin
          ef = exp_flit_q.pop_front();
          ep = exp_port_q.pop_front();
          if (out_flit !== ef || out_port !== PW'(ep)) begin
            failures++;
            $display("FAIL %s order cyc=%0d: flit=%h port=%0d required %h %0d",
                     name, cyc, out_flit, out_port, ef, ep);
          end
        end
        xfer_q.push_back(cyc);
      end

      p_valid = out_valid; p_ready = out_ready; p_busy = busy; p_out_flit = out_flit;
      p_req = in_req; p_ack = in_ack; p_grant = grant; p_tail = |(in_ack & in_tail);
      for (int p = 0; p < NP; p++) begin
        if (in_ack[p]) begin
          p_ack_flit = in_flit[p*FW +: FW];
          p_ack_port = PW'(p);
        end
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (p_ack[p] && src_rd[p] < src_len[p]) src_rd[p]++;
      end
      cyc++;
    end
    checks++;
    if (exp_flit_q.size() != 0) begin
      failures++;
      $display("FAIL %s timeout: %0d flits outstanding required 0", name, exp_flit_q.size());
    end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (src_rd[p] != src_len[p]) begin
        failures++;
        $display("FAIL %s source_drain port=%0d: popped=%0d required %0d", name, p, src_rd[p], src_len[p]);
      end
    end
    $display("txn %s: flits=%0d cycles=%0d", name, xfer_q.size(), cyc);
    in_req = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_req = '0; in_tail = '0; in_flit = '0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({in_ack, out_valid, out_flit, out_port, grant, busy} !== '0) begin
      failures++;
      $display("FAIL reset_async: ack=%b valid=%b flit=%h port=%0d grant=%b busy=%b required all 0",
               in_ack, out_valid, out_flit, out_port, grant, busy);
    end
    checks++;
    if ({fp_in_ack, fp_out_valid, fp_out_flit, fp_out_port, fp_grant, fp_busy} !== '0) begin
      failures++;
      $display("FAIL reset_async_fp: grant=%b valid=%b busy=%b required all 0", fp_grant, fp_out_valid, fp_busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({in_ack, out_valid, grant, busy} !== '0) begin
        failures++;
        $display("FAIL reset_idle c=%0d: ack=%b valid=%b grant=%b busy=%b required all 0",
                 c, in_ack, out_valid, grant, busy);
      end
    end
    $display("txn reset done");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int p = 0; p < NP; p++) begin npk[p] = 2; len_cfg[p] = 1; end
    max_len = 1;
    build_traffic();
    run_traffic("round_robin", 100, 0, 400);
    checks++;
    if (xfer_q.size() != 2 * NP) begin
      failures++;
      $display("FAIL rr_count: flits=%0d required %0d", xfer_q.size(), 2 * NP);
    end
    for (int i = 1; i < xfer_q.size(); i++) begin
      checks++;
      if (xfer_q[i] - xfer_q[i-1] != 2) begin
        failures++;
        $display("FAIL rr_spacing i=%0d: gap=%0d required 2", i, xfer_q[i] - xfer_q[i-1]);
      end
    end
  endtask

  task automatic test_packet_lock();
    do_reset();
    npk[0] = 2; npk[1] = 1; npk[2] = 1; npk[3] = 0; npk[4] = 1;
    for (int p = 0; p < NP; p++) len_cfg[p] = 1;
    len_cfg[2] = 4;
    max_len = 4;
    build_traffic();
    run_traffic("packet_lock", 100, 0, 400);
    // Stream is port 0, 1, then the four port-2 flits back to back.
    for (int i = 3; i <= 5 && i < xfer_q.size(); i++) begin
      checks++;
      if (xfer_q[i] - xfer_q[i-1] != 1) begin
        failures++;
        $display("FAIL lock_throughput i=%0d: gap=%0d required 1", i, xfer_q[i] - xfer_q[i-1]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int p = 0; p < NP; p++) begin npk[p] = 3; len_cfg[p] = 0; end
    max_len = 6;
    build_traffic();
    run_traffic("backpressure", 50, 25, 3000);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int p = 0; p < NP; p++) begin npk[p] = int'($urandom_range(0, 4)); len_cfg[p] = 0; end
      max_len = 8;
      build_traffic();
      run_traffic("random", 70, 40, 4000);
    end
  endtask

  task automatic test_fixed_prio();
    int fp_wins;
    int rr3;
    do_reset();
    in_req = 5'b01010; in_tail = '1; out_ready = 1'b1;
    for (int p = 0; p < NP; p++) in_flit[p*FW +: FW] = $urandom;
    fp_wins = 0;
    rr3 = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (fp_grant != '0) fp_wins++;
      if (grant[3]) rr3++;
      checks++;
      if (fp_grant !== 5'b00000 && fp_grant !== 5'b00010) begin
        failures++;
        $display("FAIL fixed_grant c=%0d: grant=%b required 00010 or 0", c, fp_grant);
      end
      checks++;
      if (fp_in_ack[3] !== 1'b0 || fp_busy !== (fp_grant != '0)) begin
        failures++;
        $display("FAIL fixed_ack c=%0d: ack=%b busy=%b grant=%b required ack[3]=0 busy=|grant",
                 c, fp_in_ack, fp_busy, fp_grant);
      end
      if (fp_out_valid) begin
        checks++;
        if (fp_out_port !== 3'd1 || fp_out_flit !== in_flit[FW +: FW]) begin
          failures++;
          $display("FAIL fixed_out c=%0d: port=%0d flit=%h required 1 %h", c, fp_out_port, fp_out_flit, in_flit[FW +: FW]);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (fp_wins < 14) begin
      failures++;
      $display("FAIL fixed_wins: grants=%0d required >=14", fp_wins);
    end
    checks++;
    if (rr3 < 5) begin
      failures++;
      $display("FAIL rr_alternates: port3 grants=%0d required >=5", rr3);
    end
    $display("txn fixed_prio: port1 grants=%0d rr port3 grants=%0d", fp_wins, rr3);
    in_req = '0;
  endtask

  task automatic test_mid_reset();
    int acks;
    bit seen;
    do_reset();
    in_req = 5'b00010; in_tail = '0; out_ready = 1'b1;
    for (int p = 0; p < NP; p++) in_flit[p*FW +: FW] = $urandom;
    acks = 0;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (in_ack[1]) acks++;
      if (acks == 2) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL mid_reset_setup: acks=%0d required 2", acks);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, grant, busy, in_ack, out_port} !== '0 || out_flit !== '0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b grant=%b busy=%b ack=%b flit=%h required all 0",
               out_valid, grant, busy, in_ack, out_flit);
    end
    in_req = 5'b10000; in_tail = 5'b10000;
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 5'b10000 || busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_grant: grant=%b busy=%b valid=%b required 10000 1 0", grant, busy, out_valid);
    end
    $display("txn mid_reset: grant=%b", grant);
    in_req = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_random();
    test_fixed_prio();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_port_arbiter.md
# noc_port_arbiter

Registered N-input packet arbiter for a NoC router output channel. It replaces the combinational first-new-port priority chain. Each input port raises a request when a new packet head is waiting. The block grants one port by rotating round-robin or fixed priority, then locks onto that port until its tail flit has been forwarded into a one-deep output register with a valid/ready handshake.

## Interface
- NUM_PORTS, 5, number of competing input ports (2..8)
- FLIT_W, 32, flit width in bits
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority, lowest index wins
- PORT_W, derived, max(1, clog2(NUM_PORTS)); not overridable
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous active-high reset
- in_req  input  NUM_PORTS  bit i: port i has a flit available (head or body)
- in_tail  input  NUM_PORTS  bit i: flit presented by port i is the packet tail
- in_flit  input  NUM_PORTS*FLIT_W  port i flit at bits [i*FLIT_W +: FLIT_W]
- in_ack  output  NUM_PORTS  one-hot pop strobe to the granted port (combinational)
- out_valid  output  1  output register holds a flit
- out_ready  input  1  downstream accepts flit this cycle
- out_flit  output  FLIT_W  registered flit
- out_port  output  PORT_W  source index of out_flit
- grant  output  NUM_PORTS  registered one-hot current owner; all-zero when idle
- busy  output  1  high while in LOCKED

## Operation
- The FSM has two states, IDLE and LOCKED. The round-robin pointer ptr is PORT_W bits wide and resets to 0.
- **IDLE**
  - grant = 0 and in_ack = 0.
  - If in_req is non-zero, the winner is the first requesting index in the order ptr, ptr+1, …, NUM_PORTS-1, 0, …, ptr-1.
  - With FIXED_PRIO=1, the search always starts at 0.
  - The winner is loaded into sel and grant. Next state is LOCKED.
  - No flit moves during the arbitration cycle.
- **LOCKED**
  - in_ack[sel] = in_req[sel] & (~out_valid | out_ready). All other in_ack bits are 0.
  - On ack: out_flit <= in_flit[sel], out_port <= sel, out_valid <= 1.
  - If in_tail[sel] is high on the ack: next state IDLE, grant <= 0, ptr <= (sel == NUM_PORTS-1) ? 0 : sel+1.
  - With FIXED_PRIO=1, ptr stays at 0.
- **Output register**
  - If out_valid & out_ready and there is no ack that cycle, out_valid <= 0.
  - out_flit and out_port hold their value while out_valid=1 and out_ready=0.
- **Boundary behaviour**
  - A single-flit packet (head with in_tail=1) returns to IDLE after one transfer.
  - in_req[sel] dropping mid-packet is a bubble. The lock is held and no other port is served.
  - in_req bits of other ports are ignored in LOCKED.
  - On wrap-around at ptr = NUM_PORTS-1 the search continues at 0.
  - A port requesting alone wins regardless of ptr.
  - Requests arriving in the cycle the tail is acked are evaluated in the next cycle (IDLE).
- **Reset**
  - Any cycle, including mid-packet. Asynchronous assertion forces state IDLE, ptr 0, sel 0, grant 0, busy 0, out_valid 0, out_flit 0, out_port 0, so in_ack = 0.
  - A partially forwarded packet is abandoned. Upstream flushing is not this block's job.

## Timing
- Reset values of all outputs are 0.
- Arbitration latency: 1 cycle from in_req seen in IDLE to grant/busy high.
- First ack is in the cycle after the grant. out_valid rises 1 cycle after the ack.
- Throughput while LOCKED with out_ready=1 and in_req[sel]=1 is one flit per cycle.
- Packet-to-packet overhead: one idle arbitration cycle after each tail.
- in_ack is combinational from registered state, in_req and out_ready. There is no combinational path from in_flit to any output.

## Test plan
- **Reset:** rst high, then low with in_req=0 -> all outputs 0, state stays IDLE.
- **Round-robin fairness:** NUM_PORTS=5, all ports issue continuous single-flit packets, out_ready=1 -> out_port sequence 0,1,2,3,4,0…, one flit every 2 cycles.
- **Packet lock:** port 2 sends 4 flits (tail on the 4th) while ports 0 and 4 request -> out_port=2 for 4 consecutive flits, then grant goes to port 3 (if requesting) else 4. Ports 0 and 4 see in_ack=0 throughout.
- **Backpressure:** out_ready=0 for 3 cycles mid-packet -> out_flit stable, in_ack=0, no flit lost or duplicated. Resumes one flit per cycle after out_ready=1.
- **Fixed priority:** FIXED_PRIO=1, ports 1 and 3 request continuously -> port 1 always wins, port 3 never granted.
- **Mid-packet reset:** rst asserted on the 2nd flit of a 3-flit packet -> out_valid=0, grant=0 immediately. After release with only port 4 requesting -> grant=5'b10000 one cycle later.
